// File: rtl/pc_pkg.sv
// Shared op encodings and sizing helper for the program-counter unit.
package pc_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_BRC  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control-unit to PC-unit bundle; signal suffixes are from the PC unit's point of view.
interface pc_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              en_i;
  logic [2:0]        op_i;
  logic              cond_i;
  logic [DATA_W-1:0] target_i;
  logic              clr_err_i;
  logic [ADDR_W-1:0] pc_o;
  logic              stack_empty_o;
  logic              stack_full_o;
  logic              stack_err_o;

  modport master (
    output en_i, op_i, cond_i, target_i, clr_err_i,
    input  pc_o, stack_empty_o, stack_full_o, stack_err_o
  );

  modport slave (
    input  en_i, op_i, cond_i, target_i, clr_err_i,
    output pc_o, stack_empty_o, stack_full_o, stack_err_o
  );
endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO with combinational top-of-stack; caller must not push when full
// or pop when empty.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] din_i,
  output logic [ADDR_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int PW = clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d, top_idx;

  always_comb begin
    ptr_d = ptr_q;
    if (push_i)     ptr_d = ptr_q + 1'b1;
    else if (pop_i) ptr_d = ptr_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Contents need no reset: an empty pointer makes every entry unreachable.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q[IW-1:0]] <= din_i;
  end

  assign top_idx = ptr_q - 1'b1;
  assign dout_o  = mem_q[top_idx[IW-1:0]];
  assign full_o  = (ptr_q == PW'(STACK_DEPTH));
  assign empty_o = (ptr_q == '0);
endmodule

// File: rtl/pc_unit.sv
// Program counter with increment, jump, signed relative branch and stacked call/return.
// New PC is visible one cycle after the op; stack misuse sets a sticky error flag.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              ADDR_W      = 8,
  parameter int              DATA_W      = 16,
  parameter int              OFF_W       = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input logic       clk,
  input logic       rst_n,
  pc_unit_if.slave  bus
);
  logic [ADDR_W-1:0]       pc_q, pc_d, pc_inc, off_ext, tgt_abs, top;
  logic                    err_q, err_d, err_set;
  logic                    push, pop, full, empty;
  logic signed [OFF_W-1:0] off_s;
  logic                    unused_tgt;

  assign pc_inc  = pc_q + 1'b1;
  assign tgt_abs = bus.target_i[ADDR_W-1:0];
  assign off_s   = bus.target_i[OFF_W-1:0];
  // A signed size cast sign-extends a short offset and truncates a long one.
  assign off_ext = ADDR_W'(off_s);
  assign unused_tgt = ^bus.target_i;

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (bus.en_i) begin
      case (bus.op_i)
        OP_INC:  pc_d = pc_inc;
        OP_JMP:  pc_d = tgt_abs;
        OP_BRC:  pc_d = bus.cond_i ? pc_q + off_ext : pc_inc;
        OP_CALL: begin
          if (full) begin
            pc_d    = pc_inc;
            err_set = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = tgt_abs;
          end
        end
        OP_RET: begin
          if (empty) begin
            pc_d    = pc_inc;
            err_set = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = top;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
    // Clear acts even while disabled; a fresh error in the same cycle wins.
    err_d = err_set ? 1'b1 : (bus.clr_err_i ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_inc),
    .dout_o  (top),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.pc_o          = pc_q;
  assign bus.stack_empty_o = empty;
  assign bus.stack_full_o  = full;
  assign bus.stack_err_o   = err_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit (depth 4) plus a depth-1 instance for the single-entry stack case.
module tb_pc_unit;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_W(8), .DATA_W(16)) b4 ();
  pc_unit_if #(.ADDR_W(8), .DATA_W(16)) b1 ();

  pc_unit #(.ADDR_W(8), .DATA_W(16), .OFF_W(8), .STACK_DEPTH(4), .RESET_VEC(8'h00))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  pc_unit #(.ADDR_W(8), .DATA_W(16), .OFF_W(8), .STACK_DEPTH(1), .RESET_VEC(8'h00))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  typedef struct {
    logic        en;
    logic [2:0]  op;
    logic        cond;
    logic [15:0] tgt;
    logic        clr;
    logic [7:0]  pc;
    logic        emp;
    logic        ful;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic en, logic [2:0] op, logic cond, logic [15:0] tgt, logic clr,
                              logic [7:0] pc, logic emp, logic ful, logic err);
    vec_t v;
    v.en = en; v.op = op; v.cond = cond; v.tgt = tgt; v.clr = clr;
    v.pc = pc; v.emp = emp; v.ful = ful; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [7:0] pc, input logic emp, input logic ful,
                      input logic err);
    chk({tag, ".pc"},    32'(b4.pc_o), 32'(pc));
    chk({tag, ".empty"}, 32'(b4.stack_empty_o), 32'(emp));
    chk({tag, ".full"},  32'(b4.stack_full_o), 32'(ful));
    chk({tag, ".err"},   32'(b4.stack_err_o), 32'(err));
  endtask

  task automatic drive4(input logic en, input logic [2:0] op, input logic cond,
                        input logic [15:0] tgt, input logic clr);
    b4.en_i = en; b4.op_i = op; b4.cond_i = cond; b4.target_i = tgt; b4.clr_err_i = clr;
  endtask

  task automatic drive1(input logic en, input logic [2:0] op, input logic [15:0] tgt);
    b1.en_i = en; b1.op_i = op; b1.cond_i = 1'b0; b1.target_i = tgt; b1.clr_err_i = 1'b0;
  endtask

  initial begin
    drive4(1'b0, OP_HOLD, 1'b0, 16'h0, 1'b0);
    drive1(1'b0, OP_HOLD, 16'h0);

    // stepped table: each row is one clock, expected state after the edge
    vecs.push_back(mk(1, OP_INC,  0, 16'h0000, 0, 8'h01, 1, 0, 0));
    vecs.push_back(mk(1, OP_INC,  0, 16'h0000, 0, 8'h02, 1, 0, 0));
    vecs.push_back(mk(1, OP_INC,  0, 16'h0000, 0, 8'h03, 1, 0, 0));
    vecs.push_back(mk(1, OP_JMP,  0, 16'h00FE, 0, 8'hFE, 1, 0, 0));
    vecs.push_back(mk(1, OP_INC,  0, 16'h0000, 0, 8'hFF, 1, 0, 0));
    vecs.push_back(mk(1, OP_INC,  0, 16'h0000, 0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, OP_INC,  0, 16'h0000, 0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(1, OP_JMP,  0, 16'h0010, 0, 8'h10, 1, 0, 0));
    vecs.push_back(mk(1, OP_BRC,  1, 16'h00F0, 0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(1, OP_JMP,  0, 16'h0010, 0, 8'h10, 1, 0, 0));
    vecs.push_back(mk(1, OP_BRC,  0, 16'h00F0, 0, 8'h11, 1, 0, 0));
    vecs.push_back(mk(1, OP_JMP,  0, 16'h1234, 0, 8'h34, 1, 0, 0));
    vecs.push_back(mk(1, OP_JMP,  0, 16'h00F0, 0, 8'hF0, 1, 0, 0));
    vecs.push_back(mk(1, OP_BRC,  1, 16'h0020, 0, 8'h10, 1, 0, 0));
    vecs.push_back(mk(1, OP_BRC,  1, 16'hFF7F, 0, 8'h8F, 1, 0, 0));
    vecs.push_back(mk(1, OP_JMP,  0, 16'h0005, 0, 8'h05, 1, 0, 0));
    vecs.push_back(mk(1, OP_CALL, 0, 16'h0040, 0, 8'h40, 0, 0, 0));
    vecs.push_back(mk(1, OP_CALL, 0, 16'h0080, 0, 8'h80, 0, 0, 0));
    vecs.push_back(mk(1, OP_RET,  0, 16'h0000, 0, 8'h41, 0, 0, 0));
    vecs.push_back(mk(1, OP_RET,  0, 16'h0000, 0, 8'h06, 1, 0, 0));
    vecs.push_back(mk(1, OP_CALL, 0, 16'h0050, 0, 8'h50, 0, 0, 0));
    vecs.push_back(mk(1, OP_CALL, 0, 16'h0060, 0, 8'h60, 0, 0, 0));
    vecs.push_back(mk(1, OP_CALL, 0, 16'h0070, 0, 8'h70, 0, 0, 0));
    vecs.push_back(mk(1, OP_CALL, 0, 16'h0020, 0, 8'h20, 0, 1, 0));
    vecs.push_back(mk(1, OP_CALL, 0, 16'h0099, 0, 8'h21, 0, 1, 1));
    vecs.push_back(mk(0, OP_CALL, 0, 16'h0099, 1, 8'h21, 0, 1, 0));
    vecs.push_back(mk(1, OP_RET,  0, 16'h0000, 0, 8'h71, 0, 0, 0));
    vecs.push_back(mk(1, OP_RET,  0, 16'h0000, 0, 8'h61, 0, 0, 0));
    vecs.push_back(mk(1, OP_RET,  0, 16'h0000, 0, 8'h51, 0, 0, 0));
    vecs.push_back(mk(1, OP_RET,  0, 16'h0000, 0, 8'h07, 1, 0, 0));
    vecs.push_back(mk(1, OP_JMP,  0, 16'h0030, 0, 8'h30, 1, 0, 0));
    vecs.push_back(mk(1, OP_RET,  0, 16'h0000, 0, 8'h31, 1, 0, 1));
    vecs.push_back(mk(1, OP_RET,  0, 16'h0000, 1, 8'h32, 1, 0, 1));
    vecs.push_back(mk(1, 3'b111,  0, 16'h0000, 0, 8'h32, 1, 0, 1));
    vecs.push_back(mk(1, 3'b110,  1, 16'h00AA, 0, 8'h32, 1, 0, 1));
    vecs.push_back(mk(1, OP_HOLD, 0, 16'h0000, 1, 8'h32, 1, 0, 0));

    #12;
    chk4("reset", 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive4(vecs[i].en, vecs[i].op, vecs[i].cond, vecs[i].tgt, vecs[i].clr);
      @(posedge clk);
      #1;
      chk4($sformatf("vec%0d", i), vecs[i].pc, vecs[i].emp, vecs[i].ful, vecs[i].err);
    end

    // async reset mid-cycle with an error pending and a call on the stack
    drive4(1'b1, OP_RET, 1'b0, 16'h0, 1'b0);
    @(posedge clk); #1;
    chk4("pre_rst_err", 8'h33, 1'b1, 1'b0, 1'b1);
    drive4(1'b1, OP_CALL, 1'b0, 16'h0077, 1'b0);
    @(posedge clk); #1;
    chk4("pre_rst_call", 8'h77, 1'b0, 1'b0, 1'b1);
    drive4(1'b1, OP_INC, 1'b0, 16'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_rst", 8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk4("rst_held", 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive4(1'b0, OP_HOLD, 1'b0, 16'h0, 1'b0);

    // single-entry stack: one call fills it, the second errors
    drive1(1'b1, OP_CALL, 16'h0040);
    @(posedge clk); #1;
    chk("d1.call.pc",   32'(b1.pc_o), 32'h40);
    chk("d1.call.full", 32'(b1.stack_full_o), 32'h1);
    chk("d1.call.empty", 32'(b1.stack_empty_o), 32'h0);
    drive1(1'b1, OP_CALL, 16'h0050);
    @(posedge clk); #1;
    chk("d1.over.pc",  32'(b1.pc_o), 32'h41);
    chk("d1.over.err", 32'(b1.stack_err_o), 32'h1);
    drive1(1'b1, OP_RET, 16'h0000);
    @(posedge clk); #1;
    chk("d1.ret.pc",    32'(b1.pc_o), 32'h01);
    chk("d1.ret.empty", 32'(b1.stack_empty_o), 32'h1);
    drive1(1'b0, OP_HOLD, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end
endmodule
